// File: rtl/spi_regbank.sv
// SPI slave with an integrated register bank, oversampled in the system clock domain.
//
// Frame: an 8-bit header (bit7 = write, bits[6:0] = start address) is followed by any
// number of REG_WIDTH-bit words. The address auto-increments after each word and wraps
// from 127 to 0. Addresses below NUM_CFG are read/write config registers. The next
// NUM_STATUS addresses are read-only status registers. All other addresses read as zero
// and reject writes.
//
// Ports:
//   clk, rstb      system clock, asynchronous active-low reset
//   ena            block enable; low aborts any frame and forces spi_miso low
//   mode           SPI mode {CPOL, CPHA}; only sampled while idle
//   spi_cs_n/clk/mosi/miso   SPI pins (MSB first); spi_clk must be <= clk/8
//   config_regs    flat config bus, register k at [k*REG_WIDTH +: REG_WIDTH]
//   cfg_wr_stb     one-cycle pulse on bit k when config k is written
//   access_err     one-cycle pulse when a write to a non-config address is rejected
//   status_regs    flat status bus, same packing as config_regs
module spi_regbank #(
  parameter int unsigned NUM_CFG    = 8,
  parameter int unsigned NUM_STATUS = 4,
  parameter int unsigned REG_WIDTH  = 8,
  parameter logic [NUM_CFG*REG_WIDTH-1:0] CFG_RESET = '0
) (
  input  logic                             clk,
  input  logic                             rstb,
  input  logic                             ena,
  input  logic [1:0]                       mode,
  input  logic                             spi_cs_n,
  input  logic                             spi_clk,
  input  logic                             spi_mosi,
  output logic                             spi_miso,
  output logic [NUM_CFG*REG_WIDTH-1:0]     config_regs,
  output logic [NUM_CFG-1:0]               cfg_wr_stb,
  output logic                             access_err,
  input  logic [NUM_STATUS*REG_WIDTH-1:0]  status_regs
);

  // Input shift register must hold a full header as well as a full word.
  localparam int unsigned SW = (REG_WIDTH > 8) ? REG_WIDTH : 8;
  localparam logic [4:0] WordLast = 5'(REG_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

  state_e                         state_q, state_d;
  logic                           sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic                           cs_meta_q, cs_sync_q, cs_prev_q;
  logic                           mosi_meta_q, mosi_sync_q;
  logic [1:0]                     mode_q, mode_d;
  logic [4:0]                     bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]                  shift_q, shift_d;
  logic [6:0]                     ptr_q, ptr_d;
  logic                           is_wr_q, is_wr_d;
  logic [REG_WIDTH-1:0]           tx_q, tx_d;
  logic                           miso_q, miso_d;
  logic [NUM_CFG*REG_WIDTH-1:0]   cfg_q, cfg_d;
  logic [NUM_CFG-1:0]             stb_q, stb_d;
  logic                           err_q, err_d;

  logic                           sclk_rise, sclk_fall, sample_on_rise;
  logic                           sample_edge, shift_edge, cs_fall;
  logic [SW-1:0]                  nxt_shift;
  logic [REG_WIDTH-1:0]           word;
  logic [6:0]                     rd_addr;
  logic [REG_WIDTH-1:0]           rd_word;

  assign sclk_rise      = sclk_sync_q & ~sclk_prev_q;
  assign sclk_fall      = ~sclk_sync_q & sclk_prev_q;
  assign cs_fall        = cs_prev_q & ~cs_sync_q;
  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
  assign sample_on_rise = ~(mode_q[1] ^ mode_q[0]);
  assign sample_edge    = sample_on_rise ? sclk_rise : sclk_fall;
  assign shift_edge     = sample_on_rise ? sclk_fall : sclk_rise;
  assign nxt_shift      = {shift_q[SW-2:0], mosi_sync_q};
  assign word           = nxt_shift[REG_WIDTH-1:0];

  // Address of the word to load into the TX register: the header's start address when the
  // header completes, otherwise the address following the word just completed.
  assign rd_addr = (state_q == StHdr) ? nxt_shift[6:0] : ptr_q + 7'd1;

  always_comb begin
    rd_word = '0;
    for (int unsigned k = 0; k < NUM_CFG; k++) begin
      if (32'(rd_addr) == k) rd_word = cfg_q[k*REG_WIDTH +: REG_WIDTH];
    end
    for (int unsigned k = 0; k < NUM_STATUS; k++) begin
      if (32'(rd_addr) == NUM_CFG + k) rd_word = status_regs[k*REG_WIDTH +: REG_WIDTH];
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    is_wr_d   = is_wr_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    cfg_d     = cfg_q;
    stb_d     = '0;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        mode_d    = mode;
        miso_d    = 1'b0;
        bit_cnt_d = '0;
        if (ena && cs_fall) state_d = StHdr;
      end
      StHdr: begin
        miso_d = 1'b0;
        if (sample_edge) begin
          shift_d = nxt_shift;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = '0;
            is_wr_d   = nxt_shift[7];
            ptr_d     = nxt_shift[6:0];
            state_d   = StData;
            if (!nxt_shift[7]) tx_d = rd_word;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      StData: begin
        if (sample_edge) begin
          shift_d = nxt_shift;
          if (bit_cnt_q == WordLast) begin
            bit_cnt_d = '0;
            ptr_d     = ptr_q + 7'd1;
            if (is_wr_q) begin
              if (32'(ptr_q) >= NUM_CFG) err_d = 1'b1;
              for (int unsigned k = 0; k < NUM_CFG; k++) begin
                if (32'(ptr_q) == k) begin
                  cfg_d[k*REG_WIDTH +: REG_WIDTH] = word;
                  stb_d[k]                        = 1'b1;
                end
              end
            end else begin
              tx_d = rd_word;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        if (shift_edge) begin
          if (is_wr_q) begin
            miso_d = 1'b0;
          end else begin
            miso_d = tx_q[REG_WIDTH-1];
            tx_d   = tx_q << 1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort is evaluated after sampling so a word completing in this cycle still commits.
    if (state_q != StIdle && (cs_sync_q || !ena)) begin
      state_d = StIdle;
      miso_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_prev_q   <= 1'b1;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      state_q     <= StIdle;
      mode_q      <= 2'b00;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      is_wr_q     <= 1'b0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      cfg_q       <= CFG_RESET;
      stb_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      sclk_meta_q <= spi_clk;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      cs_meta_q   <= spi_cs_n;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      mosi_meta_q <= spi_mosi;
      mosi_sync_q <= mosi_meta_q;
      state_q     <= state_d;
      mode_q      <= mode_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      is_wr_q     <= is_wr_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      cfg_q       <= cfg_d;
      stb_q       <= stb_d;
      err_q       <= err_d;
    end
  end

  // Gate with ena so the pin drops immediately rather than one cycle later.
  assign spi_miso    = miso_q & ena;
  assign config_regs = cfg_q;
  assign cfg_wr_stb  = stb_q;
  assign access_err  = err_q;

endmodule

// File: tb/tb_spi_regbank.sv
module tb_spi_regbank;

  localparam int unsigned NC   = 8;
  localparam int unsigned NS   = 4;
  localparam int unsigned W    = 8;
  localparam int          HALF = 80;  // SPI half period: 8 system clocks
  localparam logic [NC*W-1:0] RST_IMG = 64'h1807_2605_3403_4201;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          ena = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          cs_n = 1'b1;
  logic          sclk = 1'b0;
  logic          mosi = 1'b0;
  logic          miso;
  logic [NC*W-1:0] cfg;
  logic [NC-1:0] stb;
  logic          err;
  logic [NS*W-1:0] status = '0;

  always #5 clk = ~clk;

  spi_regbank #(
    .NUM_CFG   (NC),
    .NUM_STATUS(NS),
    .REG_WIDTH (W),
    .CFG_RESET (RST_IMG)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .ena        (ena),
    .mode       (mode),
    .spi_cs_n   (cs_n),
    .spi_clk    (sclk),
    .spi_mosi   (mosi),
    .spi_miso   (miso),
    .config_regs(cfg),
    .cfg_wr_stb (stb),
    .access_err (err),
    .status_regs(status)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [7:0] cfg_m[NC];
  int         stb_exp[NC];
  int         err_exp = 0;
  int         stb_seen[NC];
  int         err_seen = 0;
  logic [7:0] tx_buf[8];
  logic [7:0] rx_buf[8];

  initial for (int k = 0; k < NC; k++) begin
    stb_exp[k]  = 0;
    stb_seen[k] = 0;
  end

  always @(posedge clk) begin
    if (rstb) begin
      for (int k = 0; k < NC; k++) if (stb[k]) stb_seen[k]++;
      if (err) err_seen++;
    end
  end

  function automatic logic [7:0] model_rd(input int a);
    if (a < NC) return cfg_m[a];
    if (a < NC + NS) return status[(a-NC)*8 +: 8];
    return 8'h00;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NC; k++) cfg_m[k] = RST_IMG[k*8 +: 8];
  endtask

  task automatic model_write(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      int a;
      a = (start + i) % 128;
      if (a < NC) begin
        cfg_m[a] = tx_buf[i];
        stb_exp[a]++;
      end else begin
        err_exp++;
      end
    end
  endtask

  task automatic check_reads(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      int a;
      a = (start + i) % 128;
      check_eq($sformatf("read_addr%0d", a), 64'(rx_buf[i]), 64'(model_rd(a)));
    end
  endtask

  task automatic check_state(input string tag);
    logic [63:0] img;
    for (int k = 0; k < NC; k++) img[k*8 +: 8] = cfg_m[k];
    check_eq({tag, "_cfg"}, 64'(cfg), img);
    for (int k = 0; k < NC; k++)
      check_eq($sformatf("%s_stb%0d", tag, k), 64'(stb_seen[k]), 64'(stb_exp[k]));
    check_eq({tag, "_err"}, 64'(err_seen), 64'(err_exp));
  endtask

  // SPI master: header then nwords words; the final word is cut to last_bits bits.
  task automatic spi_xfer(input logic [1:0] md, input logic [7:0] hdr, input int nwords,
                          input int last_bits);
    logic       cpol, cpha;
    logic [7:0] byte_v;
    int         nb;
    cpol = md[1];
    cpha = md[0];
    mode = md;
    sclk = cpol;
    #200;
    cs_n = 1'b0;
    #100;
    for (int w = 0; w <= nwords; w++) begin
      byte_v = (w == 0) ? hdr : tx_buf[w-1];
      nb     = (w == nwords && w > 0) ? last_bits : 8;
      if (w > 0) rx_buf[w-1] = 8'h00;
      for (int b = 7; b > 7 - nb; b--) begin
        if (!cpha) begin
          mosi = byte_v[b];
          #HALF;
          if (w > 0) rx_buf[w-1][b] = miso;
          sclk = ~cpol;
          #HALF;
          sclk = cpol;
        end else begin
          sclk = ~cpol;
          mosi = byte_v[b];
          #HALF;
          if (w > 0) rx_buf[w-1][b] = miso;
          sclk = cpol;
          #HALF;
        end
      end
    end
    #HALF;
    cs_n = 1'b1;
    mosi = 1'b0;
    #300;
  endtask

  task automatic fill_tx_random();
    for (int i = 0; i < 8; i++) tx_buf[i] = 8'($urandom);
  endtask

  initial begin
    model_reset();
    #52;
    check_eq("reset_cfg", 64'(cfg), 64'(RST_IMG));
    check_eq("reset_stb", 64'(stb), 64'd0);
    check_eq("reset_err", 64'(err), 64'd0);
    check_eq("reset_miso", 64'(miso), 64'd0);
    rstb = 1'b1;
    ena  = 1'b1;
    #100;

    // Mode 0 burst write to config 2 and 3
    tx_buf[0] = 8'hA5;
    tx_buf[1] = 8'h3C;
    spi_xfer(2'd0, 8'h82, 2, 8);
    model_write(2, 2);
    check_state("burst_wr");

    // Each mode: write/read back config 0, read status 0
    for (int md = 0; md < 4; md++) begin
      tx_buf[0] = 8'h5A;
      spi_xfer(2'(md), 8'h80, 1, 8);
      model_write(0, 1);
      status[7:0] = 8'h77;
      fill_tx_random();
      spi_xfer(2'(md), 8'h00, 1, 8);
      check_reads(0, 1);
      spi_xfer(2'(md), 8'h08, 1, 8);
      check_reads(8, 1);
    end
    check_state("modes");

    // Burst read across the end of status into unmapped space
    status = 32'hC3D4_E5F6;
    spi_xfer(2'd0, 8'h0A, 4, 8);
    check_reads(10, 4);

    // Rejected write, then wrap from 127 to 0
    tx_buf[0] = 8'hFF;
    spi_xfer(2'd0, 8'h8B, 1, 8);
    model_write(11, 1);
    check_state("err_wr");
    tx_buf[0] = 8'h11;
    tx_buf[1] = 8'h96;
    spi_xfer(2'd1, 8'hFF, 2, 8);
    model_write(127, 2);
    check_state("wrap");

    // Aborted word after 5 bits, then a normal frame
    tx_buf[0] = 8'hE7;
    spi_xfer(2'd0, 8'h81, 1, 5);
    check_state("abort");
    tx_buf[0] = 8'h4D;
    spi_xfer(2'd0, 8'h81, 1, 8);
    model_write(1, 1);
    check_state("after_abort");

    // ena dropped mid-frame: read drives 0, write is ignored
    fork
      spi_xfer(2'd0, 8'h01, 1, 8);
      begin
        #1700;
        ena = 1'b0;
        for (int i = 0; i < 4; i++) begin
          #300;
          check_eq("ena_off_miso", 64'(miso), 64'd0);
        end
      end
    join
    ena = 1'b1;
    tx_buf[0] = 8'h00;
    fork
      spi_xfer(2'd0, 8'h84, 1, 8);
      begin
        #1700;
        ena = 1'b0;
      end
    join
    ena = 1'b1;
    check_state("ena_off");

    // Asynchronous reset during a read frame
    fork
      spi_xfer(2'd0, 8'h01, 2, 8);
      begin
        #1700;
        rstb = 1'b0;
        #1;
        check_eq("midreset_cfg", 64'(cfg), 64'(RST_IMG));
        check_eq("midreset_miso", 64'(miso), 64'd0);
        #50;
        rstb = 1'b1;
      end
    join
    model_reset();
    check_state("post_reset");

    // Randomised bursts against the model
    for (int it = 0; it < 40; it++) begin
      logic [1:0] md;
      int         start, n;
      md     = 2'($urandom_range(0, 3));
      start  = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 15) : $urandom_range(0, 127);
      n      = $urandom_range(1, 3);
      status = 32'($urandom);
      fill_tx_random();
      if ($urandom_range(0, 1) == 1) begin
        spi_xfer(md, 8'h80 | 8'(start), n, 8);
        model_write(start, n);
      end else begin
        spi_xfer(md, 8'(start), n, 8);
        check_reads(start, n);
      end
    end
    check_state("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
